// File: rtl/if_stage_if.sv
// IF-stage bundle: IF->ID handshake, branch redirect from decode, and instruction SRAM port.
// Revision: 1.0
`default_nettype none

`ifndef BR_DATA_WIDTH
`define BR_DATA_WIDTH 33
`endif
`ifndef to_ID_data_width
`define to_ID_data_width 64
`endif

interface if_stage_if;
  logic                          id_allow_in;
  logic [`BR_DATA_WIDTH-1:0]     br_data;
  logic                          if_to_id_valid;
  logic [`to_ID_data_width-1:0]  to_id_data;
  logic                          inst_sram_en;
  logic [3:0]                    inst_sram_we;
  logic [31:0]                   inst_sram_addr;
  logic [31:0]                   inst_sram_wdata;
  logic [31:0]                   inst_sram_rdata;

  modport master (
    input  id_allow_in, br_data, inst_sram_rdata,
    output if_to_id_valid, to_id_data,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output id_allow_in, br_data, inst_sram_rdata,
    input  if_to_id_valid, to_id_data,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage (pre-IF PC generation, 1-cycle SRAM fetch, hold buffer).
// Optional macro IF_PERF_CNT_EN adds the fetch_cnt delivered-instruction counter port.
// Revision: 1.0
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  wire logic         clk,
  input  wire logic         reset,
`ifdef IF_PERF_CNT_EN
  output      logic [31:0]  fetch_cnt,
`endif
  if_stage_if.master        bus
);

  logic        preif_valid;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] nextpc;
  logic        if_ready_go;
  logic        if_allow_in;
  logic        fetch_issue;
  logic        consumed;
  logic [31:0] inst;

  assign br_taken  = bus.br_data[32];
  assign br_target = bus.br_data[31:0];

  assign nextpc      = br_taken ? br_target : if_pc + 32'd4;
  assign if_ready_go = 1'b1;
  // A redirect always frees the IF slot so the target can be fetched immediately.
  assign if_allow_in = ~if_valid | bus.id_allow_in | br_taken;
  assign fetch_issue = preif_valid & if_allow_in & ~reset;

  assign bus.if_to_id_valid = if_valid & if_ready_go & ~br_taken;
  assign consumed           = bus.if_to_id_valid & bus.id_allow_in;

  assign bus.inst_sram_en    = fetch_issue;
  assign bus.inst_sram_we    = 4'b0000;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = 32'h0;

  assign inst           = buf_valid ? inst_buf : bus.inst_sram_rdata;
  assign bus.to_id_data = {if_pc, inst};

  always_ff @(posedge clk) begin
    if (reset) begin
      preif_valid <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= RESET_PC - 32'd4;
      buf_valid   <= 1'b0;
      inst_buf    <= 32'h0;
    end else begin
      preif_valid <= 1'b1;
      if (fetch_issue) begin
        if_valid  <= 1'b1;
        if_pc     <= nextpc;
        buf_valid <= 1'b0;
      end else if (br_taken || consumed) begin
        if_valid  <= 1'b0;
        buf_valid <= 1'b0;
      end else if (if_valid && !buf_valid) begin
        // Stalled: SRAM output is only valid for one cycle, so latch it.
        buf_valid <= 1'b1;
        inst_buf  <= bus.inst_sram_rdata;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'h0;
    end else if (consumed) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a 1-cycle-latency SRAM that returns its address.
// Revision: 1.0
`default_nettype none

module tb_if_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic        corrupt;
  logic [31:0] sram_q;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  if_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt (fetch_cnt),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.inst_sram_en) sram_q <= bus.inst_sram_addr;
  end
  assign bus.inst_sram_rdata = corrupt ? 32'hdeadbeef : sram_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge, apply inputs, let combinational logic settle.
  task automatic cyc(input logic rst_v, input logic allow, input logic [32:0] br);
    @(negedge clk);
    reset           = rst_v;
    bus.id_allow_in = allow;
    bus.br_data     = br;
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    corrupt         = 1'b0;
    sram_q          = 32'h0;
    reset           = 1'b1;
    bus.id_allow_in = 1'b1;
    bus.br_data     = 33'h0;
    repeat (3) @(posedge clk);

    // Still in reset
    cyc(1'b1, 1'b1, 33'h0);
    chk("rst_valid", {63'h0, bus.if_to_id_valid}, 64'h0);
    chk("rst_en",    {63'h0, bus.inst_sram_en},   64'h0);
    chk("rst_pc",    {32'h0, bus.to_id_data[63:32]}, {32'h0, 32'h1bfffffc});
    chk("rst_we",    {32'h0, 28'h0, bus.inst_sram_we, bus.inst_sram_wdata}, 64'h0);

    // Release cycle: no fetch yet
    cyc(1'b0, 1'b1, 33'h0);
    chk("rel_en",    {63'h0, bus.inst_sram_en},   64'h0);
    chk("rel_valid", {63'h0, bus.if_to_id_valid}, 64'h0);
`ifdef IF_PERF_CNT_EN
    chk("cnt_rst",   {32'h0, fetch_cnt}, 64'h0);
`endif

    // First fetch
    cyc(1'b0, 1'b1, 33'h0);
    chk("first_en",   {63'h0, bus.inst_sram_en}, 64'h1);
    chk("first_addr", {32'h0, bus.inst_sram_addr}, {32'h0, 32'h1c000000});
    chk("first_valid",{63'h0, bus.if_to_id_valid}, 64'h0);

    // Streaming
    cyc(1'b0, 1'b1, 33'h0);
    chk("s0_valid", {63'h0, bus.if_to_id_valid}, 64'h1);
    chk("s0_data",  bus.to_id_data, {32'h1c000000, 32'h1c000000});
    chk("s0_addr",  {32'h0, bus.inst_sram_addr}, {32'h0, 32'h1c000004});
    cyc(1'b0, 1'b1, 33'h0);
    chk("s1_data",  bus.to_id_data, {32'h1c000004, 32'h1c000004});
    chk("s1_addr",  {32'h0, bus.inst_sram_addr}, {32'h0, 32'h1c000008});

    // Stall three cycles holding pc 0x1c000008
    cyc(1'b0, 1'b0, 33'h0);
    chk("st1_en",   {63'h0, bus.inst_sram_en}, 64'h0);
    chk("st1_data", bus.to_id_data, {32'h1c000008, 32'h1c000008});
    chk("st1_valid",{63'h0, bus.if_to_id_valid}, 64'h1);
    cyc(1'b0, 1'b0, 33'h0);
    corrupt = 1'b1;
    #1;
    chk("st2_en",   {63'h0, bus.inst_sram_en}, 64'h0);
    chk("st2_data", bus.to_id_data, {32'h1c000008, 32'h1c000008});
    cyc(1'b0, 1'b0, 33'h0);
    chk("st3_en",   {63'h0, bus.inst_sram_en}, 64'h0);
    chk("st3_data", bus.to_id_data, {32'h1c000008, 32'h1c000008});

    // Release: consume and issue together
    cyc(1'b0, 1'b1, 33'h0);
    chk("rls_en",   {63'h0, bus.inst_sram_en}, 64'h1);
    chk("rls_addr", {32'h0, bus.inst_sram_addr}, {32'h0, 32'h1c00000c});
    chk("rls_data", bus.to_id_data, {32'h1c000008, 32'h1c000008});
    corrupt = 1'b0;

    cyc(1'b0, 1'b1, 33'h0);
    chk("s3_data",  bus.to_id_data, {32'h1c00000c, 32'h1c00000c});
`ifdef IF_PERF_CNT_EN
    chk("cnt_stream", {32'h0, fetch_cnt}, {32'h0, 32'd3});
`endif

    // Single-cycle redirect while IF holds 0x1c000010
    cyc(1'b0, 1'b1, {1'b1, 32'h1c000100});
    chk("br_valid", {63'h0, bus.if_to_id_valid}, 64'h0);
    chk("br_addr",  {32'h0, bus.inst_sram_addr}, {32'h0, 32'h1c000100});
    chk("br_en",    {63'h0, bus.inst_sram_en}, 64'h1);
    cyc(1'b0, 1'b1, 33'h0);
    chk("br_tgt_valid", {63'h0, bus.if_to_id_valid}, 64'h1);
    chk("br_tgt_data",  bus.to_id_data, {32'h1c000100, 32'h1c000100});

    // Redirect held 4 cycles with decode stalled
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, {1'b1, 32'h1c000200});
      chk("hold_en",    {63'h0, bus.inst_sram_en}, 64'h1);
      chk("hold_addr",  {32'h0, bus.inst_sram_addr}, {32'h0, 32'h1c000200});
      chk("hold_valid", {63'h0, bus.if_to_id_valid}, 64'h0);
    end
    cyc(1'b0, 1'b1, 33'h0);
    chk("hold_dlv_valid", {63'h0, bus.if_to_id_valid}, 64'h1);
    chk("hold_dlv_data",  bus.to_id_data, {32'h1c000200, 32'h1c000200});
    cyc(1'b0, 0, 33'h0);
    chk("hold_next_pc", {32'h0, bus.to_id_data[63:32]}, {32'h0, 32'h1c000204});
    cyc(1'b0, 1'b0, 33'h0);
    chk("buf_hold_data", bus.to_id_data, {32'h1c000204, 32'h1c000204});

    // Reset with IF_valid=1 and buffer full
    cyc(1'b1, 1'b0, 33'h0);
    chk("mrst_en", {63'h0, bus.inst_sram_en}, 64'h0);
    cyc(1'b0, 1'b1, 33'h0);
    chk("mrst_valid", {63'h0, bus.if_to_id_valid}, 64'h0);
    chk("mrst_en2",   {63'h0, bus.inst_sram_en}, 64'h0);
    chk("mrst_pc",    {32'h0, bus.to_id_data[63:32]}, {32'h0, 32'h1bfffffc});
`ifdef IF_PERF_CNT_EN
    chk("cnt_mrst",   {32'h0, fetch_cnt}, 64'h0);
`endif
    cyc(1'b0, 1'b1, 33'h0);
    chk("refetch_en",   {63'h0, bus.inst_sram_en}, 64'h1);
    chk("refetch_addr", {32'h0, bus.inst_sram_addr}, {32'h0, 32'h1c000000});
    cyc(1'b0, 1'b1, 33'h0);
    chk("refetch_data", bus.to_id_data, {32'h1c000000, 32'h1c000000});
    chk("refetch_valid",{63'h0, bus.if_to_id_valid}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
